// File: rtl/pc_seq.sv
// Strobe sequencer for the 16-bit PC address register: INC, JMP, relative BRANCH
// (with 6502-style page-cross fixup cycle) and NOP, one command at a time.
module pc_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic [1:0] cmd,
    input  logic [7:0] offset,
    input  logic [7:0] target_l,
    input  logic [7:0] target_h,
    input  logic [7:0] pc_l_cur,
    input  logic [7:0] pc_h_cur,
    output logic       load_pc_l,
    output logic       load_pc_h,
    output logic       L_inc,
    output logic       H_inc,
    output logic [7:0] PCL_in,
    output logic [7:0] PCH_in,
    output logic       busy,
    output logic       done,
    output logic       page_cross
);

    localparam logic [1:0] CMD_INC    = 2'b00;
    localparam logic [1:0] CMD_JMP    = 2'b01;
    localparam logic [1:0] CMD_BRANCH = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXEC   = 2'd1,
        BR_FIX = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] pch_lat_q, pch_lat_d;
    logic       fwd_q, fwd_d;
    logic       bwd_q, bwd_d;

    logic       load_l_q, load_l_d;
    logic       load_h_q, load_h_d;
    logic       l_inc_q, l_inc_d;
    logic       h_inc_q, h_inc_d;
    logic [7:0] pcl_q, pcl_d;
    logic [7:0] pch_q, pch_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pcx_q, pcx_d;

    logic [8:0] br_sum;
    logic       br_cross;

    // Sign of the offset disagreeing with the carry out means the high byte must move.
    assign br_sum   = {1'b0, pc_l_cur} + {1'b0, offset};
    assign br_cross = offset[7] ^ br_sum[8];

    // Outputs are registered, so the next-cycle outputs are computed here
    // alongside the next state.
    always_comb begin
        state_d   = state_q;
        pch_lat_d = pch_lat_q;
        fwd_d     = fwd_q;
        bwd_d     = bwd_q;
        load_l_d  = 1'b0;
        load_h_d  = 1'b0;
        l_inc_d   = 1'b0;
        h_inc_d   = 1'b0;
        pcl_d     = pcl_q;
        pch_d     = pch_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        pcx_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d   = EXEC;
                    busy_d    = 1'b1;
                    pch_lat_d = pc_h_cur;
                    fwd_d     = 1'b0;
                    bwd_d     = 1'b0;
                    case (cmd)
                        CMD_INC: begin
                            l_inc_d = 1'b1;
                            done_d  = 1'b1;
                        end
                        CMD_JMP: begin
                            load_l_d = 1'b1;
                            load_h_d = 1'b1;
                            pcl_d    = target_l;
                            pch_d    = target_h;
                            done_d   = 1'b1;
                        end
                        CMD_BRANCH: begin
                            load_l_d = 1'b1;
                            pcl_d    = br_sum[7:0];
                            if (br_cross) begin
                                fwd_d = ~offset[7];
                                bwd_d = offset[7];
                            end else begin
                                done_d = 1'b1;
                            end
                        end
                        default: begin
                            done_d = 1'b1;
                        end
                    endcase
                end
            end
            EXEC: begin
                if (fwd_q || bwd_q) begin
                    state_d = BR_FIX;
                    busy_d  = 1'b1;
                    done_d  = 1'b1;
                    pcx_d   = 1'b1;
                    if (fwd_q) begin
                        h_inc_d = 1'b1;
                    end else begin
                        load_h_d = 1'b1;
                        pch_d    = pch_lat_q - 8'd1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            BR_FIX: begin
                state_d = IDLE;
                fwd_d   = 1'b0;
                bwd_d   = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pch_lat_q <= 8'h00;
            fwd_q     <= 1'b0;
            bwd_q     <= 1'b0;
            load_l_q  <= 1'b0;
            load_h_q  <= 1'b0;
            l_inc_q   <= 1'b0;
            h_inc_q   <= 1'b0;
            pcl_q     <= 8'h00;
            pch_q     <= 8'h00;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pcx_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pch_lat_q <= pch_lat_d;
            fwd_q     <= fwd_d;
            bwd_q     <= bwd_d;
            load_l_q  <= load_l_d;
            load_h_q  <= load_h_d;
            l_inc_q   <= l_inc_d;
            h_inc_q   <= h_inc_d;
            pcl_q     <= pcl_d;
            pch_q     <= pch_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pcx_q     <= pcx_d;
        end
    end

    assign load_pc_l  = load_l_q;
    assign load_pc_h  = load_h_q;
    assign L_inc      = l_inc_q;
    assign H_inc      = h_inc_q;
    assign PCL_in     = pcl_q;
    assign PCH_in     = pch_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign page_cross = pcx_q;

endmodule

// File: tb/tb_pc_seq.sv
// Directed bench for pc_seq: each command's strobe pattern, branch page-cross
// cases, async abort and back-to-back acceptance spacing.
module tb_pc_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic [1:0] cmd;
    logic [7:0] offset, target_l, target_h, pc_l_cur, pc_h_cur;
    logic       load_pc_l, load_pc_h, L_inc, H_inc, busy, done, page_cross;
    logic [7:0] PCL_in, PCH_in;

    int n_chk  = 0;
    int n_pass = 0;

    localparam logic [1:0] C_INC = 2'b00, C_JMP = 2'b01, C_BR = 2'b10, C_NOP = 2'b11;

    // {load_pc_l, load_pc_h, L_inc, H_inc, busy, done, page_cross}
    logic [6:0] flg;
    assign flg = {load_pc_l, load_pc_h, L_inc, H_inc, busy, done, page_cross};

    pc_seq dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd(cmd), .offset(offset),
        .target_l(target_l), .target_h(target_h), .pc_l_cur(pc_l_cur), .pc_h_cur(pc_h_cur),
        .load_pc_l(load_pc_l), .load_pc_h(load_pc_h), .L_inc(L_inc), .H_inc(H_inc),
        .PCL_in(PCL_in), .PCH_in(PCH_in), .busy(busy), .done(done), .page_cross(page_cross)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic chk_out(input string tag, input logic [6:0] ef,
                           input logic [7:0] el, input logic [7:0] eh);
        chk({tag, ".flags"}, {25'd0, flg}, {25'd0, ef});
        chk({tag, ".pcl"}, {24'd0, PCL_in}, {24'd0, el});
        chk({tag, ".pch"}, {24'd0, PCH_in}, {24'd0, eh});
    endtask

    // Call just after a falling edge; returns at the falling edge of cycle N+1.
    task automatic send(input logic [1:0] c, input logic [7:0] off, input logic [7:0] tl,
                        input logic [7:0] th, input logic [7:0] pl, input logic [7:0] ph);
        cmd = c; offset = off; target_l = tl; target_h = th;
        pc_l_cur = pl; pc_h_cur = ph; cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        pc_l_cur = 8'hAA; pc_h_cur = 8'h55; offset = 8'h11;
        target_l = 8'hEE; target_h = 8'hDD;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd = C_NOP; offset = 8'h00;
        target_l = 8'h00; target_h = 8'h00; pc_l_cur = 8'h00; pc_h_cur = 8'h00;
        repeat (3) @(negedge clk);
        chk_out("reset", 7'b0000000, 8'h00, 8'h00);
        rst = 1'b0;
        @(negedge clk);
        chk_out("idle", 7'b0000000, 8'h00, 8'h00);

        send(C_INC, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        chk_out("inc", 7'b0010110, 8'h00, 8'h00);
        @(negedge clk);
        chk_out("inc.after", 7'b0000000, 8'h00, 8'h00);

        send(C_JMP, 8'h00, 8'h12, 8'h34, 8'h00, 8'h00);
        chk_out("jmp", 7'b1100110, 8'h12, 8'h34);
        @(negedge clk);
        chk_out("jmp.hold", 7'b0000000, 8'h12, 8'h34);

        send(C_BR, 8'h20, 8'h00, 8'h00, 8'hF0, 8'h20);
        chk_out("brfwd.n1", 7'b1000100, 8'h10, 8'h34);
        @(negedge clk);
        chk_out("brfwd.n2", 7'b0001111, 8'h10, 8'h34);
        @(negedge clk);
        chk_out("brfwd.after", 7'b0000000, 8'h10, 8'h34);

        send(C_BR, 8'hF0, 8'h00, 8'h00, 8'h05, 8'h00);
        chk_out("brbwd.n1", 7'b1000100, 8'hF5, 8'h34);
        @(negedge clk);
        chk_out("brbwd.n2", 7'b0100111, 8'hF5, 8'hFF);
        @(negedge clk);
        chk_out("brbwd.after", 7'b0000000, 8'hF5, 8'hFF);

        send(C_BR, 8'hFE, 8'h00, 8'h00, 8'h40, 8'h30);
        chk_out("brnox", 7'b1000110, 8'h3E, 8'hFF);
        @(negedge clk);
        chk_out("brnox.after", 7'b0000000, 8'h3E, 8'hFF);

        send(C_BR, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h12);
        chk_out("br0", 7'b1000110, 8'hFF, 8'hFF);
        @(negedge clk);

        // -128 from 0x107F lands in page 0x0F; pc_h changed after accept must not matter
        send(C_BR, 8'h80, 8'h00, 8'h00, 8'h7F, 8'h10);
        chk_out("br80.n1", 7'b1000100, 8'hFF, 8'hFF);
        @(negedge clk);
        chk_out("br80.n2", 7'b0100111, 8'hFF, 8'h0F);
        @(negedge clk);

        send(C_NOP, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        chk_out("nop", 7'b0000110, 8'hFF, 8'h0F);
        @(negedge clk);

        // reset while a forward cross is pending
        send(C_BR, 8'h20, 8'h00, 8'h00, 8'hF0, 8'h20);
        chk_out("abort.n1", 7'b1000100, 8'h10, 8'h0F);
        #1 rst = 1'b1;
        #1 chk_out("abort.async", 7'b0000000, 8'h00, 8'h00);
        @(negedge clk);
        chk_out("abort.held", 7'b0000000, 8'h00, 8'h00);
        rst = 1'b0;
        @(negedge clk);
        chk_out("abort.nofix", 7'b0000000, 8'h00, 8'h00);
        send(C_INC, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        chk_out("abort.inc", 7'b0010110, 8'h00, 8'h00);
        @(negedge clk);

        // cmd_valid held high: accepts only every second edge
        cmd = C_BR; offset = 8'hFE; pc_l_cur = 8'h40; pc_h_cur = 8'h30; cmd_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i % 2 == 0) chk_out($sformatf("b2b.%0d", i), 7'b1000110, 8'h3E, 8'h00);
            else            chk_out($sformatf("b2b.%0d", i), 7'b0000000, 8'h3E, 8'h00);
        end
        cmd_valid = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
